// File: rtl/bambu_preload_pkg.sv
// Shared constants for the mergesort preload/run controller.
// Holds the state encodings, the slave access-size codes and default bus widths.
package bambu_preload_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DATA_W_DEF = 16;

    // Values placed on S_data_ram_size (access size in bits)
    localparam logic [7:0] SIZE_BYTE = 8'd8;
    localparam logic [7:0] SIZE_HALF = 8'd16;

    // Controller states
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_COLLECT    = 3'd1;
    localparam logic [2:0] ST_COLLECT_LO = 3'd2;
    localparam logic [2:0] ST_WRITE      = 3'd3;
    localparam logic [2:0] ST_WAIT_ACK   = 3'd4;
    localparam logic [2:0] ST_START      = 3'd5;
    localparam logic [2:0] ST_RUN        = 3'd6;
    localparam logic [2:0] ST_REPORT     = 3'd7;

endpackage

// File: rtl/bambu_slave_preload_ctrl_if.sv
// Bus bundle between the preload controller and its neighbours:
//   byte stream   : in_valid, in_ready, in_byte, in_last
//   kernel control: start_port, done_port
//   slave RAM port: S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size, Sout_DataRdy
// master = the controller, slave = host stream source plus the accelerator.
interface bambu_slave_preload_ctrl_if #(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CH     = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [7:0]        in_byte;
    logic              in_last;
    logic              start_port;
    logic              done_port;
    logic [CH-1:0]     S_oe_ram;
    logic [CH-1:0]     S_we_ram;
    logic [ADDR_W-1:0] S_addr_ram;
    logic [DATA_W-1:0] S_Wdata_ram;
    logic [7:0]        S_data_ram_size;
    logic [CH-1:0]     Sout_DataRdy;

    modport master (
        input  in_valid, in_byte, in_last, done_port, Sout_DataRdy,
        output in_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram,
               S_Wdata_ram, S_data_ram_size
    );

    modport slave (
        output in_valid, in_byte, in_last, done_port, Sout_DataRdy,
        input  in_ready, start_port, S_oe_ram, S_we_ram, S_addr_ram,
               S_Wdata_ram, S_data_ram_size
    );
endinterface

// File: rtl/slave_byte_packer.sv
// Pairs incoming bytes into little-endian halfwords and tracks the slave write address.
// Ports:
//   load_base  : first byte of a preload; wr_addr takes base_addr
//   take_byte  : a stream byte is accepted this cycle
//   take_hi    : the accepted byte is the upper half of a pair
//   advance    : the current write was acknowledged; step wr_addr by the access size
//   wr_addr/wr_data/wr_size : payload presented on the slave port
//   wr_last    : the payload contains the final stream byte
module slave_byte_packer
    import bambu_preload_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_base,
    input  logic              take_byte,
    input  logic              take_hi,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        in_byte,
    input  logic              in_last,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [7:0]        wr_size,
    output logic              wr_last
);
    logic [7:0] lo;

    // Pairing, odd-tail zero extension and address stepping (wraps naturally at 2^ADDR_W)
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_addr <= '0;
            wr_data <= '0;
            wr_size <= '0;
            wr_last <= 1'b0;
            lo      <= '0;
        end else if (take_byte) begin
            if (load_base) begin
                wr_addr <= base_addr;
            end
            wr_last <= in_last;
            if (take_hi) begin
                wr_data <= DATA_W'({in_byte, lo});
                wr_size <= SIZE_HALF;
            end else begin
                lo <= in_byte;
                if (in_last) begin
                    wr_data <= DATA_W'({8'h00, in_byte});
                    wr_size <= SIZE_BYTE;
                end
            end
        end else if (advance) begin
            wr_addr <= wr_addr + ((wr_size == SIZE_HALF) ? ADDR_W'(2) : ADDR_W'(1));
        end
    end
endmodule

// File: rtl/bambu_slave_preload_ctrl.sv
// Run controller in front of the HLS mergesort `main` kernel: preloads kernel memory
// from a byte stream over slave channel 0, pulses start_port, then times the run.
// Ports:
//   clock, reset (async, active-low)
//   base_addr    : first byte address, sampled with the first accepted byte
//   run_req      : level request to launch the kernel
//   busy         : controller not idle
//   result_valid : one-cycle pulse at the end of a run, with timed_out and cycles
//   bus          : byte stream, kernel start/done and slave RAM port
// All outputs are registered decodes of the next state.
module bambu_slave_preload_ctrl
    import bambu_preload_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned CH          = 2,
    parameter int unsigned TIMEOUT_CYC = 200000000,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              run_req,
    output logic              busy,
    output logic              result_valid,
    output logic              timed_out,
    output logic [CNT_W-1:0]  cycles,
    bambu_slave_preload_ctrl_if.master bus
);
    logic [2:0]        state, state_d;
    logic              preload_done, preload_done_d;
    logic              byte_seen, byte_seen_d;
    logic [CNT_W-1:0]  cnt, cnt_d, cycles_d;
    logic              timed_out_d;
    logic              in_ready_q, in_ready_d, we_q, we_d, start_q, start_d;
    logic              busy_d, result_valid_d;
    logic              collect_c, accept_c, ack_c;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [7:0]        wr_size;
    logic              wr_last;
    logic              unused_ack_hi;

    assign collect_c = (state == ST_IDLE) || (state == ST_COLLECT) || (state == ST_COLLECT_LO);
    assign accept_c  = bus.in_valid & in_ready_q & collect_c;
    // Acknowledges only count once the write strobe has been retired
    assign ack_c     = (state == ST_WAIT_ACK) & bus.Sout_DataRdy[0];
    assign unused_ack_hi = ^bus.Sout_DataRdy[CH-1:1];

    slave_byte_packer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_packer (
        .clock     (clock),
        .reset     (reset),
        .load_base (accept_c & (state == ST_IDLE)),
        .take_byte (accept_c),
        .take_hi   (state == ST_COLLECT),
        .advance   (ack_c),
        .base_addr (base_addr),
        .in_byte   (bus.in_byte),
        .in_last   (bus.in_last),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_size   (wr_size),
        .wr_last   (wr_last)
    );

    // Next-state, run timer and next output values
    always_comb begin
        state_d        = state;
        preload_done_d = preload_done;
        byte_seen_d    = byte_seen;
        cnt_d          = cnt;
        cycles_d       = cycles;
        timed_out_d    = timed_out;
        case (state)
            ST_IDLE: begin
                // A byte takes priority over a simultaneous run request
                if (accept_c) begin
                    byte_seen_d = 1'b1;
                    state_d     = bus.in_last ? ST_WRITE : ST_COLLECT;
                end else if (run_req && (preload_done || !byte_seen)) begin
                    state_d = ST_START;
                end
            end
            ST_COLLECT_LO: if (accept_c) state_d = bus.in_last ? ST_WRITE : ST_COLLECT;
            ST_COLLECT:    if (accept_c) state_d = ST_WRITE;
            ST_WRITE:      state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (ack_c) begin
                    if (wr_last) begin
                        state_d        = ST_IDLE;
                        preload_done_d = 1'b1;
                    end else begin
                        state_d = ST_COLLECT_LO;
                    end
                end
            end
            ST_START: begin
                cnt_d       = CNT_W'(1);
                byte_seen_d = 1'b0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // done wins over a timeout in the same cycle
                if (bus.done_port) begin
                    cycles_d    = cnt;
                    timed_out_d = 1'b0;
                    state_d     = ST_REPORT;
                end else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
                    cycles_d    = CNT_W'(TIMEOUT_CYC);
                    timed_out_d = 1'b1;
                    state_d     = ST_REPORT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            ST_REPORT: begin
                preload_done_d = 1'b0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d     = (state_d == ST_IDLE) || (state_d == ST_COLLECT) || (state_d == ST_COLLECT_LO);
        we_d           = (state_d == ST_WRITE);
        start_d        = (state_d == ST_START);
        busy_d         = (state_d != ST_IDLE);
        result_valid_d = (state_d == ST_REPORT);
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            preload_done <= 1'b0;
            byte_seen    <= 1'b0;
            cnt          <= '0;
            cycles       <= '0;
            timed_out    <= 1'b0;
            in_ready_q   <= 1'b0;
            we_q         <= 1'b0;
            start_q      <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_d;
            preload_done <= preload_done_d;
            byte_seen    <= byte_seen_d;
            cnt          <= cnt_d;
            cycles       <= cycles_d;
            timed_out    <= timed_out_d;
            in_ready_q   <= in_ready_d;
            we_q         <= we_d;
            start_q      <= start_d;
            busy         <= busy_d;
            result_valid <= result_valid_d;
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.start_port      = start_q;
    assign bus.S_oe_ram        = '0;
    assign bus.S_we_ram        = CH'(we_q);
    assign bus.S_addr_ram      = wr_addr;
    assign bus.S_Wdata_ram     = wr_data;
    assign bus.S_data_ram_size = wr_size;
endmodule
